// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, default datapath widths
// and the NOP word that decode also uses as its bubble instruction.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_INSTR_W = 16;

  localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HAVE  = 3'd2,
    ST_REDIR = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Saturating cycle counter for the fetch request watchdog. 'expired' is raised
// during the TIMEOUT-th consecutive enabled cycle after a clear.
module fetch_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one memory read per PC value, valid/ready hand-off
// to decode, and PC incr/load control including branch redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_incr,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               fetch_err
);

  fetch_state_t      state, state_n;
  logic              flush, flush_n;
  logic [ADDR_W-1:0] tgt, tgt_n;
  logic [ADDR_W-1:0] addr_n;
  logic              incr_n;
  logic              err_n;
  logic              take;
  logic              expired;
  logic              in_req;

  assign in_req = (state == ST_REQ);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_req),
    .en      (in_req),
    .expired (expired)
  );

  always_comb begin
    state_n = state;
    flush_n = flush;
    tgt_n   = tgt;
    addr_n  = mem_addr;
    incr_n  = 1'b0;
    err_n   = fetch_err;
    take    = 1'b0;

    if (br_taken && (state != ST_ERR)) begin
      tgt_n = br_target;
    end

    case (state)
      ST_IDLE: begin
        // mem_addr shadows the PC while parked so REQ never reads pc combinationally
        addr_n = pc;
        if (br_taken) begin
          state_n = ST_REDIR;
        end else if (enable) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          flush_n = 1'b0;
          if (flush || br_taken) begin
            state_n = ST_REDIR;
          end else begin
            take    = 1'b1;
            incr_n  = 1'b1;
            addr_n  = mem_addr + 1'b1;
            state_n = ST_HAVE;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          flush_n = 1'b0;
          state_n = ST_ERR;
        end else if (br_taken) begin
          flush_n = 1'b1;
        end
      end
      ST_HAVE: begin
        if (br_taken) begin
          state_n = ST_REDIR;
        end else if (instr_ready) begin
          state_n = enable ? ST_REQ : ST_IDLE;
        end
      end
      ST_REDIR: begin
        // a fresh branch here rides the next request as a flush and redirects again
        addr_n  = tgt;
        flush_n = br_taken;
        state_n = ST_REQ;
      end
      ST_ERR: begin
        state_n = ST_ERR;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      flush     <= 1'b0;
      tgt       <= '0;
      mem_addr  <= '0;
      pc_incr   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_n;
      flush     <= flush_n;
      tgt       <= tgt_n;
      mem_addr  <= addr_n;
      pc_incr   <= incr_n;
      fetch_err <= err_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr    <= INSTR_W'(NOP_INSTR);
      instr_pc <= '0;
    end else if (take) begin
      instr    <= mem_rdata;
      instr_pc <= mem_addr;
    end
  end

  assign mem_req     = in_req;
  assign instr_valid = (state == ST_HAVE);
  assign pc_load     = (state == ST_REDIR);
  assign pc_target   = tgt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a behavioural PC, a memory with programmable ack
// delay, directed scenarios and a randomized run against an address-stream model.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [7:0]  pc;
  logic        pc_incr;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        fetch_err;

  logic [7:0]  pc_preload;
  logic [7:0]  ack_delay;
  logic        ack_hold;
  logic [7:0]  wait_cnt;

  int checks;
  int errors;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .pc          (pc),
    .pc_incr     (pc_incr),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] memf(input logic [7:0] a);
    return {a ^ 8'h5A, a + 8'h31};
  endfunction

  // Program counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       pc <= pc_preload;
    else if (pc_load) pc <= pc_target;
    else if (pc_incr) pc <= pc + 8'd1;
  end

  // Instruction memory: acks after ack_delay cycles of mem_req
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  wait_cnt <= 8'd0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
    else                         wait_cnt <= 8'd0;
  end

  assign mem_ack   = mem_req && !ack_hold && (wait_cnt == ack_delay);
  assign mem_rdata = mem_ack ? memf(mem_addr) : 16'hDEAD;

  task automatic do_reset(input logic [7:0] pre);
    @(negedge clock);
    reset       = 1'b0;
    enable      = 1'b0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_target   = 8'h00;
    ack_hold    = 1'b0;
    ack_delay   = 8'd0;
    pc_preload  = pre;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(8'h11);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (pc_incr !== 1'b0)     begin errors++; $display("FAIL reset_pc_incr got %0b want 0", pc_incr); end
    checks++; if (pc_load !== 1'b0)     begin errors++; $display("FAIL reset_pc_load got %0b want 0", pc_load); end
    checks++; if (pc_target !== 8'h00)  begin errors++; $display("FAIL reset_pc_target got %h want 00", pc_target); end
    checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    checks++; if (mem_addr !== 8'h00)   begin errors++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== 16'h0000)   begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
    checks++; if (instr_pc !== 8'h00)   begin errors++; $display("FAIL reset_instr_pc got %h want 00", instr_pc); end
    checks++; if (fetch_err !== 1'b0)   begin errors++; $display("FAIL reset_fetch_err got %0b want 0", fetch_err); end
  endtask

  task automatic test_sequential;
    int n, c, incr, load;
    logic [7:0]  pcs [3];
    logic [15:0] ins [3];
    int          cy  [3];
    logic [7:0]  e;
    n = 0; c = 0; incr = 0; load = 0;
    do_reset(8'h03);
    enable = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clock);
      c++;
      incr += int'(pc_incr);
      load += int'(pc_load);
      if (instr_valid && instr_ready) begin
        pcs[n] = instr_pc; ins[n] = instr; cy[n] = c; n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL seq_words got %0d want 3", n); end
    for (int k = 0; k < n; k++) begin
      e = 8'(3 + k);
      checks++; if (pcs[k] !== e)       begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", k, pcs[k], e); end
      checks++; if (ins[k] !== memf(e)) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", k, ins[k], memf(e)); end
      if (k > 0) begin
        checks++; if (cy[k] - cy[k-1] != 2) begin errors++; $display("FAIL seq_spacing[%0d] got %0d want 2", k, cy[k] - cy[k-1]); end
      end
    end
    checks++; if (incr != 3) begin errors++; $display("FAIL seq_pc_incr got %0d want 3", incr); end
    checks++; if (load != 0) begin errors++; $display("FAIL seq_pc_load got %0d want 0", load); end
  endtask

  task automatic test_stall;
    int incr;
    logic found;
    logic [7:0]  hpc;
    logic [15:0] hin;
    incr = 0; found = 1'b0; hpc = 8'h00; hin = 16'h0000;
    do_reset(8'h20);
    enable = 1'b1; ack_delay = 8'd1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      incr += int'(pc_incr);
      if (instr_valid) begin found = 1'b1; hpc = instr_pc; hin = instr; end
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_valid got 0 want 1"); end
    checks++; if (hpc !== 8'h20)       begin errors++; $display("FAIL stall_pc got %h want 20", hpc); end
    checks++; if (hin !== memf(8'h20)) begin errors++; $display("FAIL stall_instr got %h want %h", hin, memf(8'h20)); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      incr += int'(pc_incr);
      checks++;
      if (instr_valid !== 1'b1 || instr !== hin || instr_pc !== hpc || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%0b i=%h p=%h req=%0b want v=1 i=%h p=%h req=0",
                 j, instr_valid, instr, instr_pc, mem_req, hin, hpc);
      end
    end
    checks++; if (incr != 1) begin errors++; $display("FAIL stall_pc_incr got %0d want 1", incr); end
    instr_ready = 1'b1;
    found = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (instr_valid) begin found = 1'b1; hpc = instr_pc; end
    end
    checks++; if (!found || hpc !== 8'h21) begin errors++; $display("FAIL stall_next_pc got %h want 21", hpc); end
  endtask

  task automatic test_branch_req;
    int loads, incr, reqs_pre;
    logic [7:0]  ld_tgt, addr_after, vpc;
    logic [15:0] vins;
    logic prev_load, got_after, found;
    loads = 0; incr = 0; reqs_pre = 0; ld_tgt = 8'h00; addr_after = 8'h00; vpc = 8'h00;
    vins = 16'h0000; prev_load = 1'b0; got_after = 1'b0; found = 1'b0;
    do_reset(8'h10);
    enable = 1'b1; instr_ready = 1'b1; ack_delay = 8'd3;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clock);
    br_taken = 1'b1; br_target = 8'h40;
    @(negedge clock);
    br_taken = 1'b0; br_target = 8'h99;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clock);
      if (instr_valid) begin found = 1'b1; vpc = instr_pc; vins = instr; break; end
      if (prev_load && mem_req && !got_after) begin addr_after = mem_addr; got_after = 1'b1; end
      if (pc_load) begin loads++; ld_tgt = pc_target; end
      if (loads == 0 && mem_req) reqs_pre++;
      incr += int'(pc_incr);
      prev_load = pc_load;
    end
    checks++; if (!found)             begin errors++; $display("FAIL brreq_valid got 0 want 1"); end
    checks++; if (vpc !== 8'h40)       begin errors++; $display("FAIL brreq_pc got %h want 40", vpc); end
    checks++; if (vins !== memf(8'h40)) begin errors++; $display("FAIL brreq_instr got %h want %h", vins, memf(8'h40)); end
    checks++; if (loads != 1)          begin errors++; $display("FAIL brreq_loads got %0d want 1", loads); end
    checks++; if (ld_tgt !== 8'h40)    begin errors++; $display("FAIL brreq_target got %h want 40", ld_tgt); end
    checks++; if (incr != 0)           begin errors++; $display("FAIL brreq_incr got %0d want 0", incr); end
    checks++; if (addr_after !== 8'h40) begin errors++; $display("FAIL brreq_addr got %h want 40", addr_after); end
    checks++; if (reqs_pre != 3)       begin errors++; $display("FAIL brreq_req_held got %0d want 3", reqs_pre); end
  endtask

  task automatic test_branch_ack;
    int loads, incr;
    logic found;
    logic [7:0] vpc;
    loads = 0; incr = 0; found = 1'b0; vpc = 8'h00;
    do_reset(8'h30);
    enable = 1'b1; instr_ready = 1'b1; ack_delay = 8'd2;
    for (int i = 0; i < 10 && !mem_ack; i++) @(negedge clock);
    checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL brack_ack_seen got %0b want 1", mem_ack); end
    br_taken = 1'b1; br_target = 8'h55;
    @(negedge clock);
    br_taken = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clock);
      if (instr_valid) begin found = 1'b1; vpc = instr_pc; break; end
      loads += int'(pc_load);
      incr  += int'(pc_incr);
    end
    checks++; if (!found || vpc !== 8'h55) begin errors++; $display("FAIL brack_pc got %h want 55", vpc); end
    checks++; if (incr != 0)  begin errors++; $display("FAIL brack_incr got %0d want 0", incr); end
    checks++; if (loads != 1) begin errors++; $display("FAIL brack_loads got %0d want 1", loads); end
  endtask

  task automatic test_branch_idle;
    do_reset(8'h60);
    repeat (2) @(negedge clock);
    br_taken = 1'b1; br_target = 8'h77;
    @(negedge clock);
    br_taken = 1'b0; br_target = 8'h00;
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 8'h77 || mem_req !== 1'b0 || pc_incr !== 1'b0) begin
      errors++;
      $display("FAIL bridle_cycle1 got load=%0b tgt=%h req=%0b incr=%0b want load=1 tgt=77 req=0 incr=0",
               pc_load, pc_target, mem_req, pc_incr);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h77 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL bridle_cycle2 got req=%0b addr=%h load=%0b want req=1 addr=77 load=0", mem_req, mem_addr, pc_load);
    end
  endtask

  task automatic test_timeout;
    int reqc;
    logic seen, found;
    logic [7:0] vpc;
    reqc = 0; seen = 1'b0; found = 1'b0; vpc = 8'h00;
    do_reset(8'h08);
    enable = 1'b1; instr_ready = 1'b1; ack_hold = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (fetch_err) begin seen = 1'b1; break; end
      reqc += int'(mem_req);
    end
    checks++; if (!seen)          begin errors++; $display("FAIL tmo_err got 0 want 1"); end
    checks++; if (reqc != 15)     begin errors++; $display("FAIL tmo_cycles got %0d want 15", reqc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tmo_req_drop got %0b want 0", mem_req); end
    br_taken = 1'b1; br_target = 8'h22;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      br_taken = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || pc_load !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
        errors++;
        $display("FAIL tmo_terminal[%0d] got req=%0b load=%0b v=%0b err=%0b want 0 0 0 1",
                 j, mem_req, pc_load, instr_valid, fetch_err);
      end
    end
    reset = 1'b0;
    #1;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_reset_clear got %0b want 0", fetch_err); end
    do_reset(8'h08);
    enable = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (instr_valid) begin found = 1'b1; vpc = instr_pc; end
    end
    checks++; if (!found || vpc !== 8'h08 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL tmo_resume got pc=%h err=%0b want pc=08 err=0", vpc, fetch_err);
    end
  endtask

  task automatic test_wrap;
    int n;
    logic [7:0]  pcs [2];
    logic [15:0] ins [2];
    n = 0;
    do_reset(8'hFF);
    enable = 1'b1; instr_ready = 1'b1; ack_delay = 8'd1;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clock);
      if (instr_valid && instr_ready) begin pcs[n] = instr_pc; ins[n] = instr; n++; end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL wrap_words got %0d want 2", n); end
    checks++; if (n > 0 && (pcs[0] !== 8'hFF || ins[0] !== memf(8'hFF))) begin
      errors++; $display("FAIL wrap_first got %h/%h want ff/%h", pcs[0], ins[0], memf(8'hFF));
    end
    checks++; if (n > 1 && (pcs[1] !== 8'h00 || ins[1] !== memf(8'h00))) begin
      errors++; $display("FAIL wrap_second got %h/%h want 00/%h", pcs[1], ins[1], memf(8'h00));
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_addr;
    logic [7:0] pre;
    int nx;
    logic xfer;
    nx = 0;
    pre = 8'($urandom);
    exp_addr = pre;
    do_reset(pre);
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      checks++;
      if (pc_incr && pc_load) begin errors++; $display("FAIL rnd_incr_load_overlap cycle %0d got 1 want 0", i); end
      if (!mem_req) ack_delay = 8'($urandom_range(0, 4));
      instr_ready = ($urandom_range(0, 2) != 0);
      enable      = ($urandom_range(0, 5) != 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      br_target   = 8'($urandom);
      xfer = instr_valid && instr_ready;
      if (xfer) begin
        nx++;
        checks++;
        if (instr_pc !== exp_addr || instr !== memf(exp_addr)) begin
          errors++;
          $display("FAIL rnd_word cycle %0d got %h/%h want %h/%h", i, instr_pc, instr, exp_addr, memf(exp_addr));
        end
      end
      if (br_taken)  exp_addr = br_target;
      else if (xfer) exp_addr = exp_addr + 8'd1;
    end
    br_taken = 1'b0;
    checks++; if (nx < 20) begin errors++; $display("FAIL rnd_activity got %0d want >=20", nx); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    enable      = 1'b0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_target   = 8'h00;
    ack_hold    = 1'b0;
    ack_delay   = 8'd0;
    pc_preload  = 8'h00;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_req();
    test_branch_ack();
    test_branch_idle();
    test_timeout();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
